// File: rtl/bnn_pkg.sv
// Shared defaults and FSM encoding for the psum sign packer.
package bnn_pkg;

    localparam int WIDTH_DEF = 14;
    localparam int O_CH_DEF  = 64;
    localparam int OUT_W_DEF = 18;
    localparam int ACC_W_DEF = WIDTH_DEF + 4;

    function automatic int num_words(input int o_ch, input int out_w);
        return (o_ch + out_w - 1) / out_w;
    endfunction

    localparam int NW_DEF = num_words(O_CH_DEF, OUT_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/psum_sign_packer_sat_acc.sv
// One output channel: saturating psum accumulator plus the registered sign bit.
module sat_acc #(
    parameter int WIDTH = 14,
    parameter int ACC_W = 18
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load,
    input  logic             accum,
    input  logic             last,
    input  logic [WIDTH-1:0] psum,
    input  logic [ACC_W-1:0] thr,
    output logic             sign
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] acc_nx;
    logic [ACC_W:0]   sum_w;

    function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] w);
        if (w[ACC_W] != w[ACC_W-1])
            return w[ACC_W] ? ACC_MIN : ACC_MAX;
        return w[ACC_W-1:0];
    endfunction

    // The first beat of a set overwrites rather than adds, so no clear cycle is needed.
    assign base   = load ? '0 : acc_q;
    assign ext    = ACC_W'($signed(psum));
    assign sum_w  = {base[ACC_W-1], base} + {ext[ACC_W-1], ext};
    assign acc_nx = sat(sum_w);

    // Sign of a saturating acc-thr equals the exact signed comparison.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_q <= '0;
            sign  <= 1'b0;
        end else begin
            if (load || accum)
                acc_q <= acc_nx;
            if (last)
                sign <= ($signed(acc_nx) >= $signed(thr));
        end
    end

endmodule

// File: rtl/psum_sign_packer.sv
// Accumulates multi-pass psums per channel and emits packed sign bits as OUT_W words.
// Optional per-channel threshold: define PSUM_SIGN_PACKER_BIAS_EN to add bias_in.
module psum_sign_packer
    import bnn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int O_CH  = O_CH_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int ACC_W = WIDTH + 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [O_CH*WIDTH-1:0] psum_in,
    input  logic                  psum_valid_in,
    output logic                  psum_ready_out,
    input  logic [7:0]            pass_num_in,
`ifdef PSUM_SIGN_PACKER_BIAS_EN
    input  logic [O_CH*WIDTH-1:0] bias_in,
`endif
    output logic [OUT_W-1:0]      act_out,
    output logic                  act_valid_out,
    input  logic                  act_ready_in,
    output logic                  act_last_out
);

    localparam int NW = num_words(O_CH, OUT_W);
    localparam int PW = NW * OUT_W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    state_t          state;
    logic [7:0]      count;
    logic [7:0]      total;
    logic [IW-1:0]   widx;
    logic            act_valid_q;
    logic            act_last_q;
    logic [O_CH-1:0] s_q;

    logic            beat;
    logic            ld;
    logic            acc_en;
    logic            last_beat;
    logic            xfer;
    logic [7:0]      total_first;
    logic [PW-1:0]   padded;
    logic [OUT_W-1:0] word;

    assign psum_ready_out = (state != ST_EMIT);
    assign beat        = psum_valid_in && psum_ready_out;
    assign ld          = beat && (state == ST_IDLE);
    assign acc_en      = beat && (state == ST_ACCUM);
    assign total_first = (pass_num_in == 8'd0) ? 8'd1 : pass_num_in;
    assign last_beat   = ld ? (total_first == 8'd1)
                            : (acc_en && ((count + 8'd1) == total));
    assign xfer        = act_valid_q && act_ready_in;

`ifdef PSUM_SIGN_PACKER_BIAS_EN
    logic [O_CH*WIDTH-1:0] bias_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            bias_q <= '0;
        else if (ld)
            bias_q <= bias_in;
    end
`endif

    for (genvar k = 0; k < O_CH; k++) begin : g_ch
        logic [ACC_W-1:0] thr;
`ifdef PSUM_SIGN_PACKER_BIAS_EN
        // A single-pass set has its bias only on the live input, not yet in bias_q.
        assign thr = ACC_W'($signed(ld ? bias_in[WIDTH*(O_CH-k)-1 -: WIDTH]
                                       : bias_q[WIDTH*(O_CH-k)-1 -: WIDTH]));
`else
        assign thr = '0;
`endif
        sat_acc #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
        ) u_acc (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .load   (ld),
            .accum  (acc_en),
            .last   (last_beat),
            .psum   (psum_in[WIDTH*(O_CH-k)-1 -: WIDTH]),
            .thr    (thr),
            .sign   (s_q[k])
        );
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ST_IDLE;
            count       <= '0;
            total       <= '0;
            widx        <= '0;
            act_valid_q <= 1'b0;
            act_last_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld) begin
                        total <= total_first;
                        count <= 8'd1;
                        if (last_beat) begin
                            state       <= ST_EMIT;
                            widx        <= '0;
                            act_valid_q <= 1'b1;
                            act_last_q  <= (NW == 1);
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (acc_en) begin
                        count <= count + 8'd1;
                        if (last_beat) begin
                            state       <= ST_EMIT;
                            widx        <= '0;
                            act_valid_q <= 1'b1;
                            act_last_q  <= (NW == 1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (xfer) begin
                        if (widx == IW'(NW - 1)) begin
                            state       <= ST_IDLE;
                            widx        <= '0;
                            act_valid_q <= 1'b0;
                            act_last_q  <= 1'b0;
                        end else begin
                            widx       <= widx + IW'(1);
                            act_last_q <= ((widx + IW'(1)) == IW'(NW - 1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Channel 0 lands at the MSB of word 0; the tail of the last word stays zero.
    always_comb begin
        padded = '0;
        for (int k = 0; k < O_CH; k++)
            padded[PW-1-k] = s_q[k];
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < NW; i++)
            if (widx == IW'(i))
                word = padded[PW-1-OUT_W*i -: OUT_W];
    end

    assign act_out       = act_valid_q ? word : '0;
    assign act_valid_out = act_valid_q;
    assign act_last_out  = act_last_q;

endmodule

// File: tb/tb_psum_sign_packer.sv
// Directed bench for psum_sign_packer at default parameters.
module tb_psum_sign_packer;

    localparam int WIDTH = 14;
    localparam int O_CH  = 64;
    localparam int OUT_W = 18;
    localparam int NW    = 4;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b0;
    logic [O_CH*WIDTH-1:0] psum_in = '0;
    logic                  psum_valid_in = 1'b0;
    logic                  psum_ready_out;
    logic [7:0]            pass_num_in = '0;
`ifdef PSUM_SIGN_PACKER_BIAS_EN
    logic [O_CH*WIDTH-1:0] bias_in = '0;
`endif
    logic [OUT_W-1:0]      act_out;
    logic                  act_valid_out;
    logic                  act_ready_in = 1'b1;
    logic                  act_last_out;

    int n_run  = 0;
    int n_fail = 0;

    psum_sign_packer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .psum_in        (psum_in),
        .psum_valid_in  (psum_valid_in),
        .psum_ready_out (psum_ready_out),
        .pass_num_in    (pass_num_in),
`ifdef PSUM_SIGN_PACKER_BIAS_EN
        .bias_in        (bias_in),
`endif
        .act_out        (act_out),
        .act_valid_out  (act_valid_out),
        .act_ready_in   (act_ready_in),
        .act_last_out   (act_last_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [O_CH*WIDTH-1:0] set_ch(input logic [O_CH*WIDTH-1:0] v,
                                                     input int k, input int val);
        logic [WIDTH-1:0] w;
        w = WIDTH'(val);
        v[WIDTH*(O_CH-k)-1 -: WIDTH] = w;
        return v;
    endfunction

    function automatic logic [O_CH*WIDTH-1:0] fill(input int val);
        logic [O_CH*WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < O_CH; k++)
            v = set_ch(v, k, val);
        return v;
    endfunction

    // Word i, bit position OUT_W-1-b carries channel i*OUT_W+b (zero past O_CH).
    function automatic logic [OUT_W-1:0] exp_word(input logic [O_CH-1:0] s, input int i);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int b = 0; b < OUT_W; b++)
            if (i*OUT_W + b < O_CH)
                w[OUT_W-1-b] = s[i*OUT_W + b];
        return w;
    endfunction

    task automatic beat(input logic [O_CH*WIDTH-1:0] p, input logic [7:0] pn);
        int n;
        n = 0;
        psum_in       = p;
        pass_num_in   = pn;
        psum_valid_in = 1'b1;
        while (!psum_ready_out && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (n >= 50) check("beat_timeout", 64'(psum_ready_out), 64'd1);
        @(posedge clk_in); #1;
        psum_valid_in = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [O_CH-1:0] s,
                         input int stall_at, input int stall_n);
        int n;
        n = 0;
        while (!act_valid_out && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        check({tag, "_valid"}, 64'(act_valid_out), 64'd1);
        for (int i = 0; i < NW; i++) begin
            if (i == stall_at) begin
                act_ready_in  = 1'b0;
                psum_valid_in = 1'b1;
                for (int c = 0; c < stall_n; c++) begin
                    @(posedge clk_in); #1;
                    check($sformatf("%s_stall%0d_word", tag, c), 64'(act_out), 64'(exp_word(s, i)));
                    check($sformatf("%s_stall%0d_vld", tag, c), 64'(act_valid_out), 64'd1);
                    check($sformatf("%s_stall%0d_rdy", tag, c), 64'(psum_ready_out), 64'd0);
                end
                act_ready_in  = 1'b1;
                psum_valid_in = 1'b0;
            end
            check($sformatf("%s_w%0d", tag, i), 64'(act_out), 64'(exp_word(s, i)));
            check($sformatf("%s_last%0d", tag, i), 64'(act_last_out), 64'(i == NW-1));
            @(posedge clk_in); #1;
        end
        check({tag, "_done_vld"}, 64'(act_valid_out), 64'd0);
        check({tag, "_done_rdy"}, 64'(psum_ready_out), 64'd1);
    endtask

    initial begin
        logic [O_CH-1:0]       s;
        logic [O_CH*WIDTH-1:0] p;
        logic [OUT_W-1:0]      t1w [NW];

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_vld",  64'(act_valid_out), 64'd0);
        check("rst_last", 64'(act_last_out), 64'd0);
        check("rst_out",  64'(act_out), 64'd0);
        check("rst_rdy",  64'(psum_ready_out), 64'd1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Single pass, all +5: every sign 1, last word keeps 10 ones then 8 pad zeros
        t1w = '{18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FF00};
        beat(fill(5), 8'd1);
        check("t1_lat_vld", 64'(act_valid_out), 64'd1);
        check("t1_rdy_emit", 64'(psum_ready_out), 64'd0);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("t1_w%0d", i), 64'(act_out), 64'(t1w[i]));
            check($sformatf("t1_last%0d", i), 64'(act_last_out), 64'(i == NW-1));
            @(posedge clk_in); #1;
        end
        check("t1_done_vld", 64'(act_valid_out), 64'd0);

        // Three passes, channel 0 sums to -1; pass_num changes after beat 1 are ignored
        beat(set_ch(fill(1), 0, 4), 8'd3);
        check("t2_b1_vld", 64'(act_valid_out), 64'd0);
        check("t2_b1_rdy", 64'(psum_ready_out), 64'd1);
        beat(set_ch(fill(1), 0, -3), 8'd7);
        check("t2_b2_vld", 64'(act_valid_out), 64'd0);
        beat(set_ch(fill(1), 0, -2), 8'd0);
        check("t2_w0_const", 64'(act_out), 64'h1FFFF);
        s = '1; s[0] = 1'b0;
        drain("t2", s, -1, 0);

        // pass_num=0 acts as one pass; alternating signs
        p = '0;
        for (int k = 0; k < O_CH; k++) p = set_ch(p, k, (k % 2 == 0) ? 1 : -1);
        beat(p, 8'd0);
        check("t3_lat_vld", 64'(act_valid_out), 64'd1);
        check("t3_w0_const", 64'(act_out), 64'h2AAAA);
        for (int k = 0; k < O_CH; k++) s[k] = (k % 2 == 0);
        drain("t3", s, -1, 0);

        // 20 passes: ch0 -8192 saturates negative, ch1 zero is non-negative,
        // ch2 -1 per beat, others +8191 saturate positive
        p = set_ch(set_ch(set_ch(fill(8191), 0, -8192), 1, 0), 2, -1);
        for (int b = 0; b < 19; b++) beat(p, 8'd20);
        check("t4_pre_vld", 64'(act_valid_out), 64'd0);
        beat(p, 8'd20);
        check("t4_w0_const", 64'(act_out), 64'h17FFF);
        s = '1; s[0] = 1'b0; s[2] = 1'b0;
        drain("t4", s, -1, 0);

        // Back-pressure for 5 cycles on word 1 with psum_valid held high
        p = '0;
        for (int k = 0; k < O_CH; k++) p = set_ch(p, k, (k % 3 == 0) ? -2 : 2);
        beat(p, 8'd1);
        for (int k = 0; k < O_CH; k++) s[k] = (k % 3 != 0);
        drain("t5", s, 1, 5);

        // Beat offered during the final word transfer must not be taken
        beat(fill(-1), 8'd1);
        for (int i = 0; i < NW; i++) begin
            if (i == NW-1) begin
                psum_in       = fill(1);
                pass_num_in   = 8'd1;
                psum_valid_in = 1'b1;
            end
            check($sformatf("t6_w%0d", i), 64'(act_out), 64'd0);
            @(posedge clk_in); #1;
        end
        psum_valid_in = 1'b0;
        check("t6_no_take", 64'(act_valid_out), 64'd0);
        repeat (3) @(posedge clk_in);
        #1;
        check("t6_quiet", 64'(act_valid_out), 64'd0);

        // Reset mid-ACCUM after 2 of 4 beats
        beat(fill(2), 8'd4);
        beat(fill(2), 8'd4);
        rst_in = 1'b0;
        #2;
        check("t7_rst_vld",  64'(act_valid_out), 64'd0);
        check("t7_rst_last", 64'(act_last_out), 64'd0);
        check("t7_rst_out",  64'(act_out), 64'd0);
        check("t7_rst_rdy",  64'(psum_ready_out), 64'd1);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        check("t7_no_emit", 64'(act_valid_out), 64'd0);
        p = '0;
        for (int k = 0; k < O_CH; k++) p = set_ch(p, k, (k < 32) ? 1 : -1);
        beat(p, 8'd1);
        check("t7_lat_vld", 64'(act_valid_out), 64'd1);
        for (int k = 0; k < O_CH; k++) s[k] = (k < 32);
        drain("t7", s, -1, 0);

`ifdef PSUM_SIGN_PACKER_BIAS_EN
        // psum +3 against bias +4 on every channel: all signs 0
        bias_in = fill(4);
        beat(fill(3), 8'd1);
        bias_in = '0;
        drain("t8", '0, -1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
